// File: rtl/ray_scan_scheduler_pkg.sv
// ray_scan_scheduler_pkg
//   Shared types and constants for the view-ray scan scheduler:
//   FSM state encoding, canvas coordinate packing, 31-bit vector layout
//   and default canvas size.
package ray_scan_scheduler_pkg;

    // Canvas defaults follow the VGA scan parameter header (80x60 tiles).
    localparam int DEF_COLS = 80;
    localparam int DEF_ROWS = 60;

    localparam int X_W   = 7;
    localparam int Y_W   = 6;
    localparam int LOC_W = X_W + Y_W;
    localparam int VEC_W = 31;

    // View vectors: signed-ish fixed point x/y on 11 bits, z on 9 bits.
    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [8:0]  z;
    } vec31_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_VALID,
        S_DONE
    } state_t;

    // view_loc packing: x in [12:6], y in [5:0].
    function automatic logic [LOC_W-1:0] pack_loc(input logic [X_W-1:0] x,
                                                  input logic [Y_W-1:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/ray_scan_scheduler_canvas_scan_counter.sv
// canvas_scan_counter
//   Row-major x/y counter over a COLS x ROWS canvas.
//   Ports:
//     i_clk, i_rst_n   clock, synchronous active-low reset
//     i_clear          return to (0,0)
//     i_advance        step to the next pixel (held at the last pixel)
//     o_x, o_y         current coordinate
//     o_last           current coordinate is (COLS-1, ROWS-1)
module canvas_scan_counter
    import ray_scan_scheduler_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_clear,
    input  logic           i_advance,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic           o_last
);

    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic           w_last_col;
    logic           w_last_row;

    assign w_last_col = (r_x == X_W'(COLS - 1));
    assign w_last_row = (r_y == Y_W'(ROWS - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_clear) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_advance && !(w_last_col && w_last_row)) begin
            // No wrap past the final pixel; the frame ends there.
            if (w_last_col) begin
                r_x <= '0;
                r_y <= r_y + Y_W'(1);
            end else begin
                r_x <= r_x + X_W'(1);
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_last = w_last_col && w_last_row;

endmodule

// File: rtl/ray_scan_scheduler.sv
// ray_scan_scheduler
//   Walks the view-ray generator over every canvas pixel of one frame,
//   waits its fixed latency, and hands each ray downstream (valid/ready)
//   tagged with its coordinate.
//   Optional build macro RAY_SCAN_ABORT_EN adds i_abort to end a frame early.
//   Ports:
//     i_clk, i_rst_n            clock, synchronous active-low reset
//     i_start                   frame request (IDLE only)
//     i_cfg_normal, i_cfg_dist  camera config, latched on start
//     o_busy, o_done            frame in progress / one-cycle end pulse
//     o_view_normal, o_view_dist, o_view_loc   generator controls
//     i_ray_in                  generator output
//     o_ray_valid, i_ray_ready  downstream handshake
//     o_ray_out, o_ray_loc, o_ray_last         captured ray and tag
//     i_abort                   (RAY_SCAN_ABORT_EN only) drop and finish
module ray_scan_scheduler
    import ray_scan_scheduler_pkg::*;
#(
    parameter int COLS        = DEF_COLS,
    parameter int ROWS        = DEF_ROWS,
    parameter int RAY_LATENCY = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
`ifdef RAY_SCAN_ABORT_EN
    input  logic             i_abort,
`endif
    input  logic             i_start,
    input  logic [VEC_W-1:0] i_cfg_normal,
    input  logic [7:0]       i_cfg_dist,
    output logic             o_busy,
    output logic             o_done,
    output logic [VEC_W-1:0] o_view_normal,
    output logic [7:0]       o_view_dist,
    output logic [LOC_W-1:0] o_view_loc,
    input  logic [VEC_W-1:0] i_ray_in,
    output logic             o_ray_valid,
    input  logic             i_ray_ready,
    output logic [VEC_W-1:0] o_ray_out,
    output logic [LOC_W-1:0] o_ray_loc,
    output logic             o_ray_last
);

    localparam int CNT_W = (RAY_LATENCY < 1) ? 1 : $clog2(RAY_LATENCY + 1);

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    vec31_t           r_normal;
    logic [7:0]       r_dist;
    vec31_t           r_ray;
    logic [LOC_W-1:0] r_loc;
    logic             r_valid;
    logic             r_last;

    logic [X_W-1:0]   w_x;
    logic [Y_W-1:0]   w_y;
    logic             w_at_last;
    logic             w_abort;
    logic             w_lat_hit;

    // FSM strobes
    logic w_latch;   // accept start
    logic w_cap;     // capture settled ray
    logic w_adv;     // step to next pixel
    logic w_drop;    // clear ray_valid (handshake or abort)
    logic w_fin;     // leaving DONE

`ifdef RAY_SCAN_ABORT_EN
    assign w_abort = i_abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_lat_hit = (r_cnt == CNT_W'(RAY_LATENCY));

    canvas_scan_counter #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_scan (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (w_latch),
        .i_advance (w_adv),
        .o_x       (w_x),
        .o_y       (w_y),
        .o_last    (w_at_last)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        w_cap   = 1'b0;
        w_adv   = 1'b0;
        w_drop  = 1'b0;
        w_fin   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_latch = 1'b1;
                    w_next  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_abort) begin
                    w_drop = 1'b1;
                    w_next = S_DONE;
                end else if (w_lat_hit) begin
                    w_cap  = 1'b1;
                    w_next = S_VALID;
                end
            end
            S_VALID: begin
                // Abort wins over a same-cycle handshake.
                if (w_abort) begin
                    w_drop = 1'b1;
                    w_next = S_DONE;
                end else if (i_ray_ready) begin
                    w_drop = 1'b1;
                    if (r_last) begin
                        w_next = S_DONE;
                    end else begin
                        w_adv  = 1'b1;
                        w_next = S_WAIT;
                    end
                end
            end
            S_DONE: begin
                w_fin  = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_normal <= '0;
            r_dist   <= '0;
            r_ray    <= '0;
            r_loc    <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
        end else begin
            if (w_latch) begin
                r_normal <= i_cfg_normal;
                r_dist   <= i_cfg_dist;
            end

            // cnt parks at RAY_LATENCY so it never leaves its range.
            if (w_latch || w_adv)
                r_cnt <= '0;
            else if (r_state == S_WAIT && !w_lat_hit)
                r_cnt <= r_cnt + CNT_W'(1);

            if (w_cap) begin
                r_ray   <= i_ray_in;
                r_loc   <= pack_loc(w_x, w_y);
                r_last  <= w_at_last;
                r_valid <= 1'b1;
            end else if (w_drop) begin
                r_valid <= 1'b0;
            end

            if (w_fin)
                r_last <= 1'b0;
        end
    end

    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = (r_state == S_DONE);
    assign o_view_normal = r_normal;
    assign o_view_dist   = r_dist;
    assign o_view_loc    = pack_loc(w_x, w_y);
    assign o_ray_valid   = r_valid;
    assign o_ray_out     = r_ray;
    assign o_ray_loc     = r_loc;
    assign o_ray_last    = r_last;

endmodule

// File: tb/tb_ray_scan_scheduler.sv
module tb_ray_scan_scheduler;

    localparam int COLS = 4;
    localparam int ROWS = 2;
    localparam int LAT  = 2;
    localparam int NPIX = COLS * ROWS;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [30:0] i_cfg_normal = '0;
    logic [7:0]  i_cfg_dist = '0;
    logic        o_busy, o_done;
    logic [30:0] o_view_normal;
    logic [7:0]  o_view_dist;
    logic [12:0] o_view_loc;
    logic [30:0] i_ray_in;
    logic        o_ray_valid;
    logic        i_ray_ready = 1'b0;
    logic [30:0] o_ray_out;
    logic [12:0] o_ray_loc;
    logic        o_ray_last;
`ifdef RAY_SCAN_ABORT_EN
    logic        i_abort = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    ray_scan_scheduler #(.COLS(COLS), .ROWS(ROWS), .RAY_LATENCY(LAT)) dut (
        .i_clk         (clk),
        .i_rst_n       (i_rst_n),
`ifdef RAY_SCAN_ABORT_EN
        .i_abort       (i_abort),
`endif
        .i_start       (i_start),
        .i_cfg_normal  (i_cfg_normal),
        .i_cfg_dist    (i_cfg_dist),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_view_normal (o_view_normal),
        .o_view_dist   (o_view_dist),
        .o_view_loc    (o_view_loc),
        .i_ray_in      (i_ray_in),
        .o_ray_valid   (o_ray_valid),
        .i_ray_ready   (i_ray_ready),
        .o_ray_out     (o_ray_out),
        .o_ray_loc     (o_ray_loc),
        .o_ray_last    (o_ray_last)
    );

    always #5 clk = ~clk;

    // Ray generator stand-in: a pure function of location and normal,
    // delivered LAT cycles after view_loc changes.
    function automatic logic [30:0] gen_f(input logic [12:0] loc, input logic [30:0] n);
        return n ^ {loc, loc[11:0], loc[5:0]};
    endfunction

    logic [30:0] gen_d1 = '0, gen_d2 = '0;
    always @(posedge clk) begin
        gen_d1 <= gen_f(o_view_loc, o_view_normal);
        gen_d2 <= gen_d1;
    end
    assign i_ray_in = gen_d2;

    // Reference: beat k of a frame is pixel (k % COLS, k / COLS).
    function automatic logic [12:0] exp_loc(input int k);
        return 13'((k % COLS) * 64 + (k / COLS));
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: ready high; 1: stall 5 cycles on beat 3; 2: random ready;
    // 3: ready high plus a stray start (dist 9) mid-frame.
    task automatic run_frame(input int mode, input logic [30:0] nrm, input logic [7:0] dst);
        int c, beat, stalls, done_c, hold;
        bit done_seen, rdy;
        @(negedge clk);
        i_cfg_normal = nrm; i_cfg_dist = dst; i_start = 1'b1; i_ray_ready = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_cfg_normal = 31'($urandom); i_cfg_dist = 8'($urandom);
        c = 0; beat = 0; stalls = 0; hold = 0; done_c = -1; done_seen = 0;
        while (!done_seen && c < 400) begin
            if (o_done) begin
                done_seen = 1;
                done_c = c;
            end else begin
                chk("busy", o_busy, 1);
                chk("vdist", o_view_dist, dst);
                chk("vnorm", o_view_normal, nrm);
                case (mode)
                    1:       rdy = !(beat == 2 && o_ray_valid && hold < 5);
                    2:       rdy = ($urandom_range(0, 2) != 0);
                    default: rdy = 1'b1;
                endcase
                if (o_ray_valid && beat >= NPIX)
                    chk("extra_beat", beat, NPIX - 1);
                else if (o_ray_valid) begin
                    chk("loc", o_ray_loc, exp_loc(beat));
                    chk("ray", o_ray_out, gen_f(exp_loc(beat), nrm));
                    chk("last", o_ray_last, beat == NPIX - 1);
                    if (!rdy) begin
                        stalls++;
                        if (beat == 2) hold++;
                        chk("stall_vloc", o_view_loc, exp_loc(beat));
                    end else begin
                        beat++;
                    end
                end
                i_ray_ready = rdy;
                i_start = (mode == 3 && c == 10);
                if (mode == 3 && c == 10) i_cfg_dist = 8'd9;
            end
            if (!done_seen) begin
                @(negedge clk);
                c++;
            end
        end
        chk("done_seen", done_seen, 1);
        chk("done_time", done_c, NPIX * (LAT + 2) + stalls);
        chk("beats", beat, NPIX);
        if (mode == 1) chk("stall_len", hold, 5);
        @(negedge clk);
        chk("done_pulse", o_done, 0);
        chk("busy_clr", o_busy, 0);
        chk("last_clr", o_ray_last, 0);
    endtask

    initial begin
        int n;
        bit hit;
        // Reset and idle
        repeat (3) @(negedge clk);
        chk("rst_outs", {o_busy, o_done, o_ray_valid, o_ray_last, o_ray_out, o_ray_loc,
                         o_view_loc, o_view_normal, o_view_dist}, '0);
        i_rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("idle_busy", o_busy, 0);
        end

        run_frame(0, 31'h12345678, 8'd40);
        run_frame(1, 31'h12345678, 8'd40);
        run_frame(3, 31'h12345678, 8'd40);

        // Reset during beat 5
        @(negedge clk);
        i_cfg_normal = 31'h0ABCDEF; i_cfg_dist = 8'd40; i_start = 1'b1; i_ray_ready = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        n = 0; hit = 0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge clk);
            if (o_ray_valid) begin
                if (n == 4) hit = 1;
                else n++;
            end
        end
        chk("rst_reach", hit, 1);
        i_rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_outs", {o_busy, o_done, o_ray_valid, o_ray_last, o_ray_out, o_ray_loc,
                            o_view_loc, o_view_normal, o_view_dist}, '0);
        i_rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("midrst_nodone", {o_done, o_busy}, 0);
        end
        run_frame(0, 31'h0ABCDEF, 8'd40);

        // Randomized frames
        for (int f = 0; f < 3; f++)
            run_frame(2, 31'($urandom), 8'($urandom));

`ifdef RAY_SCAN_ABORT_EN
        @(negedge clk);
        i_cfg_normal = 31'h1; i_cfg_dist = 8'd40; i_start = 1'b1; i_ray_ready = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        n = 0;
        for (int k = 0; k < 200 && n < 2; k++) begin
            @(negedge clk);
            if (o_ray_valid) n++;
        end
        chk("abort_reach", n, 2);
        @(negedge clk);
        chk("abort_wait", o_ray_valid, 0);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        chk("abort_done", o_done, 1);
        chk("abort_novalid", o_ray_valid, 0);
        @(negedge clk);
        chk("abort_busy", {o_busy, o_done}, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ray_scan_scheduler.md
Name: ray_scan_scheduler

Overview:
- Sequences the view-ray generator across the whole canvas for one frame.
- Latches camera configuration (view normal, view distance) at frame start and holds it stable on the datapath.
- Steps the canvas coordinate row-major and waits the generator's fixed latency.
- Captures each 31-bit ray and hands it downstream with a valid/ready handshake, tagged with its coordinate.

Parameters:
- COLS, 80, canvas columns (x range 0..COLS-1, must fit 7 bits)
- ROWS, 60, canvas rows (y range 0..ROWS-1, must fit 6 bits)
- RAY_LATENCY, 2, clock cycles from a view_loc change to a settled ray_in (≥1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  frame request; sampled only in IDLE
- cfg_normal  in  31  view normal {x[10:0],y[10:0],z[8:0]}; latched on start
- cfg_dist  in  8  view distance; latched on start
- busy  out  1  high from start accept until done
- done  out  1  one-cycle pulse after the last ray handshake
- view_normal  out  31  latched normal to the generator
- view_dist  out  8  latched distance to the generator
- view_loc  out  13  {x[6:0],y[5:0]} to the generator
- ray_in  in  31  ray vector from the generator
- ray_valid  out  1  ray_out/ray_loc hold a captured ray
- ray_ready  in  1  downstream accepts
- ray_out  out  31  captured ray
- ray_loc  out  13  coordinate of ray_out
- ray_last  out  1  ray_out is pixel (COLS-1, ROWS-1)

Behaviour:
- Reset (rst_n=0 at an edge): every output is 0, state is IDLE, and x, y and cnt are 0. A reset mid-frame aborts the frame with no done pulse.
- FSM states: IDLE, WAIT, VALID, DONE.
- IDLE: on start=1, latch cfg_* into view_normal/view_dist, set x=y=0 and cnt=0, raise busy, and go to WAIT. start in any other state is ignored.
- WAIT: view_loc holds the current {x,y}.
  - cnt increments each cycle.
  - When cnt==RAY_LATENCY, capture ray_in into ray_out and view_loc into ray_loc. In the same edge, set ray_last = (x==COLS-1 && y==ROWS-1) and ray_valid=1, then go to VALID.
- VALID: ray_out, ray_loc, ray_last and view_loc are held stable while ray_ready=0.
- On ray_valid && ray_ready:
  - Clear ray_valid.
  - If ray_last: go to DONE.
  - Otherwise advance: x+1, or x=0 and y+1 when x==COLS-1. Set cnt=0 and go to WAIT.
- DONE: done=1 for exactly one cycle. Then busy=0, ray_last=0, and state returns to IDLE.
- Per-pixel period with ray_ready held high: RAY_LATENCY+2 cycles. Frame: COLS*ROWS*(RAY_LATENCY+2) edges from start accept to the done-high cycle.
- view_normal and view_dist never change while busy=1.
- cnt width is clog2(RAY_LATENCY+1). x, y and cnt never exceed their ranges; there is no wrap beyond the last pixel.

Optional Feature:
- Macro: RAY_SCAN_ABORT_EN.
- With the macro, an extra input port abort (1 bit) is added.
  - abort=1 in WAIT or VALID drops any pending ray (ray_valid=0) and goes to DONE. done pulses and busy clears as normal.
  - abort has priority over a simultaneous handshake.
  - abort is ignored in IDLE and DONE.
- Without the macro, the port is absent and a frame always runs to completion.

Decomposition:
- Shared package holds:
  - the FSM state encoding;
  - the view_loc packing (x in [12:6], y in [5:0]);
  - the 31-bit vector field layout;
  - COLS/ROWS defaults taken from the VGA scan parameter header.
- One natural sub-module, canvas_scan_counter: x/y row-major counter with clear, advance and last-flag outputs.

Test Plan:
- Reset and idle: COLS=4, ROWS=2, RAY_LATENCY=2; hold rst_n=0 for 3 cycles, then release with start=0 → all outputs 0 and busy stays 0 for 20 cycles.
- Full frame, no backpressure: same parameters, cfg_normal=31'h12345678&mask, cfg_dist=8'd40; pulse start with ray_ready=1 and the generator modelled with 2-cycle latency →
  - 8 beats with ray_loc in order (0,0),(1,0),(2,0),(3,0),(0,1)…(3,1);
  - ray_last only on beat 8;
  - done exactly 32 edges after start accept;
  - view_dist=40 throughout.
- Backpressure: hold ray_ready=0 for 5 cycles on beat 3 → ray_out, ray_loc=(2,0) and view_loc stable for those cycles; no beat is skipped or duplicated; done arrives 5 cycles later than the unstalled frame.
- Start ignored while busy: pulse start with different cfg_dist=8'd9 mid-frame → view_dist stays 40 and the beat count stays 8.
- Reset mid-frame: assert rst_n=0 during beat 5 → outputs 0, no done pulse; a following start runs a full 8-beat frame from (0,0).
- Abort (RAY_SCAN_ABORT_EN defined): abort=1 in WAIT of beat 3 → no beat 3 handshake; done pulses the next cycle and busy clears.
